// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID and ID/EX: load-use bubble, MUL/DIV occupancy, branch flush.
// Outputs are combinational (0-cycle) from state + inputs; optional stall counter under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_muldiv,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int OCC_W = 8;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t           state;
  logic [OCC_W-1:0] occ;
  logic             rs_match;
  logic             rt_match;
  logic             load_use;

  assign rs_match = id_uses_rs && (id_rs == ex_rt);
  assign rt_match = id_uses_rt && (id_rt == ex_rt);
  assign load_use = ex_mem_read && (ex_rt != 5'd0) && id_valid && (rs_match || rt_match);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_RUN;
      occ   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            state <= ST_FLUSH;
          end else if (load_use) begin
            state <= ST_RUN;
          end else if (id_valid && id_muldiv) begin
            occ   <= OCC_W'(MULDIV_CYCLES - 1);
            state <= ST_MULDIV;
          end
        end
        ST_MULDIV: begin
          // occ==0 is unreachable but is treated as done so the counter cannot wrap
          if (occ <= OCC_W'(1)) begin
            occ   <= '0;
            state <= ST_RUN;
          end else begin
            occ <= occ - OCC_W'(1);
          end
        end
        ST_FLUSH: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          occ   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    muldiv_busy    = 1'b0;
    case (state)
      ST_RUN: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
        end
      end
      ST_MULDIV: begin
        muldiv_busy    = 1'b1;
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    endcase
    // Reset overrides everything so the pipe holds NOPs while RST_N is low
    if (!RST_N) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      muldiv_busy    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
    end else if (!pc_write_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = '0;
`endif

  // A taken branch cannot be resolved in EX while a MUL/DIV occupies it
  a_no_branch_in_muldiv: assert property (
    @(posedge CLK) disable iff (!RST_N) !((state == ST_MULDIV) && branch_taken)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MULDIV_CYCLES=4 and CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, muldiv_busy}
  localparam logic [4:0] O_RST = 5'b00110;
  localparam logic [4:0] O_RUN = 5'b11000;
  localparam logic [4:0] O_LU  = 5'b00010;
  localparam logic [4:0] O_MD  = 5'b00011;
  localparam logic [4:0] O_FL  = 5'b11110;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             id_valid, id_uses_rs, id_uses_rt, id_muldiv;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             ex_mem_read, branch_taken;
  logic             pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, muldiv_busy;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(CNT_W)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_muldiv      (id_muldiv),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .branch_taken   (branch_taken),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .muldiv_busy    (muldiv_busy),
    .stall_count    (stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {11'd0, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, muldiv_busy};
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    return PERF ? 16'(n) : 16'd0;
  endfunction

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic md);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rs = urs;
    id_uses_rt = urt;
    id_muldiv  = md;
  endtask

  task automatic set_ex(input logic mr, input logic [4:0] rt, input logic br);
    ex_mem_read  = mr;
    ex_rt        = rt;
    branch_taken = br;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b0, 5'd0, 1'b0);

    // Reset values, then release mid-cycle
    #12;
    chk("reset_outs", outs(), 16'(O_RST));
    chk("reset_cnt", 16'(stall_count), 16'd0);
    RST_N = 1'b1;
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("run_after_release", outs(), 16'(O_RUN));

    // Load-use on rs: one bubble, then normal
    next_cyc();
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0);
    set_ex(1'b1, 5'd5, 1'b0);
    @(negedge CLK);
    chk("load_use_rs", outs(), 16'(O_LU));
    next_cyc();
    set_ex(1'b0, 5'd5, 1'b0);
    @(negedge CLK);
    chk("load_use_rs_clear", outs(), 16'(O_RUN));
    chk("cnt_after_lu_rs", 16'(stall_count), exp_cnt(1));

    // Load-use on rt
    next_cyc();
    set_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0);
    set_ex(1'b1, 5'd7, 1'b0);
    @(negedge CLK);
    chk("load_use_rt", outs(), 16'(O_LU));

    // No false hazards
    next_cyc();
    set_id(1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    set_ex(1'b1, 5'd0, 1'b0);
    @(negedge CLK);
    chk("no_haz_rt0", outs(), 16'(O_RUN));
    chk("cnt_after_lu_rt", 16'(stall_count), exp_cnt(2));
    next_cyc();
    set_id(1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 1'b0);
    set_ex(1'b1, 5'd5, 1'b0);
    @(negedge CLK);
    chk("no_haz_unused_rs", outs(), 16'(O_RUN));
    next_cyc();
    set_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("no_haz_id_invalid", outs(), 16'(O_RUN));
    next_cyc();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    set_ex(1'b0, 5'd5, 1'b0);
    @(negedge CLK);
    chk("no_haz_not_load", outs(), 16'(O_RUN));

    // MUL/DIV issue: 3 busy cycles, RUN on the 4th
    next_cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
    set_ex(1'b0, 5'd9, 1'b0);
    @(negedge CLK);
    chk("muldiv_issue", outs(), 16'(O_RUN));
    next_cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk($sformatf("muldiv_busy_%0d", i), outs(), 16'(O_MD));
      next_cyc();
    end
    @(negedge CLK);
    chk("muldiv_done", outs(), 16'(O_RUN));
    chk("cnt_after_muldiv", 16'(stall_count), exp_cnt(5));

    // Branch + load-use together: flush path only, FLUSH ignores load-use
    next_cyc();
    set_id(1'b1, 5'd6, 5'd2, 1'b1, 1'b1, 1'b0);
    set_ex(1'b1, 5'd6, 1'b1);
    @(negedge CLK);
    chk("branch_over_lu", outs(), 16'(O_FL));
    next_cyc();
    set_ex(1'b1, 5'd6, 1'b0);
    @(negedge CLK);
    chk("flush_state", outs(), 16'(O_FL));
    next_cyc();
    set_ex(1'b0, 5'd6, 1'b0);
    @(negedge CLK);
    chk("after_flush", outs(), 16'(O_RUN));
    chk("cnt_after_flush", 16'(stall_count), exp_cnt(5));

    // Load-use beats MUL/DIV issue; then reset aborts mid-MULDIV
    next_cyc();
    set_id(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b1);
    set_ex(1'b1, 5'd4, 1'b0);
    @(negedge CLK);
    chk("lu_over_muldiv", outs(), 16'(O_LU));
    next_cyc();
    set_ex(1'b0, 5'd4, 1'b0);
    @(negedge CLK);
    chk("muldiv_issue_after_lu", outs(), 16'(O_RUN));
    next_cyc();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("muldiv_busy_pre_rst", outs(), 16'(O_MD));
    chk("cnt_pre_rst", 16'(stall_count), exp_cnt(6));
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_muldiv", outs(), 16'(O_RST));
    chk("rst_mid_cnt", 16'(stall_count), 16'd0);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("run_after_abort", outs(), 16'(O_RUN));

    // 20 consecutive stall cycles: counter saturates at 15 when enabled
    next_cyc();
    set_id(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 1'b0);
    set_ex(1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 10; i++) next_cyc();
    @(negedge CLK);
    chk("cnt_10", 16'(stall_count), exp_cnt(10));
    chk("stall_held", outs(), 16'(O_LU));
    for (int i = 0; i < 10; i++) next_cyc();
    @(negedge CLK);
    chk("cnt_sat", 16'(stall_count), exp_cnt(15));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
